// File: rtl/nfc_page_copy_engine_if.sv
// Bus bundle between the page-copy engine and its surroundings: the run
// control handshake plus the split IO/control buses of flash A (source) and
// flash B (destination). The engine takes the master side.
interface nfc_page_copy_engine_if #(
    parameter int ROW_W = 16
);
    logic             start;
    logic [ROW_W-1:0] page_start;
    logic [ROW_W-1:0] page_cnt;
    logic             busy;
    logic             done;
    logic             err;
    logic [ROW_W-1:0] err_page;

    logic [7:0]       F_IO_A_in;
    logic [7:0]       F_IO_A_out;
    logic             F_IO_A_oe;
    logic             F_CLE_A;
    logic             F_ALE_A;
    logic             F_REN_A;
    logic             F_WEN_A;
    logic             F_RB_A;

    logic [7:0]       F_IO_B_in;
    logic [7:0]       F_IO_B_out;
    logic             F_IO_B_oe;
    logic             F_CLE_B;
    logic             F_ALE_B;
    logic             F_REN_B;
    logic             F_WEN_B;
    logic             F_RB_B;

    modport master (
        input  start, page_start, page_cnt,
        output busy, done, err, err_page,
        input  F_IO_A_in, F_RB_A,
        output F_IO_A_out, F_IO_A_oe, F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A,
        input  F_IO_B_in, F_RB_B,
        output F_IO_B_out, F_IO_B_oe, F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B
    );

    modport slave (
        output start, page_start, page_cnt,
        input  busy, done, err, err_page,
        output F_IO_A_in, F_RB_A,
        input  F_IO_A_out, F_IO_A_oe, F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A,
        output F_IO_B_in, F_RB_B,
        input  F_IO_B_out, F_IO_B_oe, F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B
    );
endinterface

// File: rtl/nfc_page_copy_engine.sv
// NAND page-copy engine: copies page_cnt consecutive pages from flash A to
// the same rows of flash B, streaming each byte through one register, then
// checks the program status of every page and reports the first failing row.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// RD_CMD  | read command 0x00 to A
// RD_ADDR | column + row address bytes to A
// RD_WAIT | tWB delay, then wait for A ready
// PG_CMD  | program command 0x80 to B
// PG_ADDR | column + row address bytes to B
// XFER    | stream PAGE_BYTES bytes A -> B
// PG_CONF | program confirm 0x10 to B
// PG_WAIT | tWB delay, then wait for B ready
// ST_CMD  | read status command 0x70 to B
// ST_READ | one status byte read from B
// NEXT    | advance row / count remaining pages
// DONE    | end of run, raise done
module nfc_page_copy_engine #(
    parameter int PAGE_BYTES  = 528,
    parameter int ADDR_CYCLES = 3,
    parameter int ROW_W       = 8*(ADDR_CYCLES-1),
    parameter int T_WB        = 4
) (
    input  logic clk,
    input  logic rst,
    nfc_page_copy_engine_if.master bus
);
    localparam int AW = (ADDR_CYCLES > 1) ? $clog2(ADDR_CYCLES) : 1;
    localparam int XW = $clog2(2*PAGE_BYTES+1);
    localparam int TW = (T_WB > 0) ? $clog2(T_WB+1) : 1;
    localparam logic [AW-1:0] A_LAST = AW'(ADDR_CYCLES-1);
    localparam logic [XW-1:0] X_LAST = XW'(2*PAGE_BYTES);
    localparam logic [7:0] CMD_READ = 8'h00;
    localparam logic [7:0] CMD_PROG = 8'h80;
    localparam logic [7:0] CMD_CONF = 8'h10;
    localparam logic [7:0] CMD_STAT = 8'h70;

    typedef enum logic [3:0] {
        IDLE, RD_CMD, RD_ADDR, RD_WAIT, PG_CMD, PG_ADDR, XFER,
        PG_CONF, PG_WAIT, ST_CMD, ST_READ, NEXT, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             ph;          // 0: strobe phase, 1: release phase of a 2-clock bus cycle
    logic [AW-1:0]    acnt;
    logic [XW-1:0]    xcnt;
    logic [TW-1:0]    tmr;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] cnt;
    logic [7:0]       data;
    logic [7:0]       addr_byte;
    logic             busy_q, done_q, err_q;
    logic [ROW_W-1:0] err_page_q;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_page = err_page_q;

    // Address byte for the current address cycle: column 0x00 first, then row LSB first.
    always_comb begin
        addr_byte = 8'h00;
        for (int j = 1; j < ADDR_CYCLES; j++) begin
            if (acnt == AW'(j)) addr_byte = row[8*(j-1) +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and flash pin drive, all pins idle unless the state claims them.
    always_comb begin
        state_nxt      = state;
        bus.F_CLE_A    = 1'b0;
        bus.F_ALE_A    = 1'b0;
        bus.F_REN_A    = 1'b1;
        bus.F_WEN_A    = 1'b1;
        bus.F_IO_A_oe  = 1'b0;
        bus.F_IO_A_out = 8'h00;
        bus.F_CLE_B    = 1'b0;
        bus.F_ALE_B    = 1'b0;
        bus.F_REN_B    = 1'b1;
        bus.F_WEN_B    = 1'b1;
        bus.F_IO_B_oe  = 1'b0;
        bus.F_IO_B_out = 8'h00;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = (bus.page_cnt == '0) ? DONE : RD_CMD;
            end
            RD_CMD: begin
                bus.F_CLE_A    = 1'b1;
                bus.F_IO_A_oe  = 1'b1;
                bus.F_IO_A_out = CMD_READ;
                bus.F_WEN_A    = ph;
                if (ph) state_nxt = RD_ADDR;
            end
            RD_ADDR: begin
                bus.F_ALE_A    = 1'b1;
                bus.F_IO_A_oe  = 1'b1;
                bus.F_IO_A_out = addr_byte;
                bus.F_WEN_A    = ph;
                if (ph && acnt == A_LAST) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (tmr == '0 && bus.F_RB_A) state_nxt = PG_CMD;
            end
            PG_CMD: begin
                bus.F_CLE_B    = 1'b1;
                bus.F_IO_B_oe  = 1'b1;
                bus.F_IO_B_out = CMD_PROG;
                bus.F_WEN_B    = ph;
                if (ph) state_nxt = PG_ADDR;
            end
            PG_ADDR: begin
                bus.F_ALE_B    = 1'b1;
                bus.F_IO_B_oe  = 1'b1;
                bus.F_IO_B_out = addr_byte;
                bus.F_WEN_B    = ph;
                if (ph && acnt == A_LAST) state_nxt = XFER;
            end
            XFER: begin
                // Even cycles pulse REN_A, odd cycles pulse WEN_B with the byte read before.
                bus.F_REN_A    = xcnt[0] || (xcnt == X_LAST);
                bus.F_WEN_B    = ~xcnt[0];
                bus.F_IO_B_oe  = 1'b1;
                bus.F_IO_B_out = data;
                if (xcnt == X_LAST) state_nxt = PG_CONF;
            end
            PG_CONF: begin
                bus.F_CLE_B    = 1'b1;
                bus.F_IO_B_oe  = 1'b1;
                bus.F_IO_B_out = CMD_CONF;
                bus.F_WEN_B    = ph;
                if (ph) state_nxt = PG_WAIT;
            end
            PG_WAIT: begin
                if (tmr == '0 && bus.F_RB_B) state_nxt = ST_CMD;
            end
            ST_CMD: begin
                bus.F_CLE_B    = 1'b1;
                bus.F_IO_B_oe  = 1'b1;
                bus.F_IO_B_out = CMD_STAT;
                bus.F_WEN_B    = ph;
                if (ph) state_nxt = ST_READ;
            end
            ST_READ: begin
                bus.F_REN_B = ph;
                if (ph) state_nxt = NEXT;
            end
            NEXT: begin
                state_nxt = (cnt == ROW_W'(1)) ? DONE : RD_CMD;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: bus-cycle phase, address/byte counters, tWB timer, row/count and run status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph         <= 1'b0;
            acnt       <= '0;
            xcnt       <= '0;
            tmr        <= '0;
            row        <= '0;
            cnt        <= '0;
            data       <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_page_q <= '0;
        end else begin
            case (state)
                RD_CMD, PG_CMD, PG_CONF, ST_CMD, ST_READ,
                RD_ADDR, PG_ADDR: ph <= ~ph;
                default:          ph <= 1'b0;
            endcase

            if ((state == RD_ADDR || state == PG_ADDR) && ph)
                acnt <= (acnt == A_LAST) ? '0 : acnt + 1'b1;

            if ((state == RD_ADDR && ph && acnt == A_LAST) || (state == PG_CONF && ph))
                tmr <= TW'(T_WB);
            else if ((state == RD_WAIT || state == PG_WAIT) && tmr != '0)
                tmr <= tmr - 1'b1;

            if (state == XFER) begin
                xcnt <= (xcnt == X_LAST) ? '0 : xcnt + 1'b1;
                if (!xcnt[0] && xcnt != X_LAST) data <= bus.F_IO_A_in;
            end

            if (state == IDLE && bus.start) begin
                row        <= bus.page_start;
                cnt        <= bus.page_cnt;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                err_page_q <= '0;
            end

            // Status bit0 set means the program failed; only the first failing row is kept.
            if (state == ST_READ && !ph && bus.F_IO_B_in[0]) begin
                err_q <= 1'b1;
                if (!err_q) err_page_q <= row;
            end

            if (state == NEXT) begin
                cnt <= cnt - 1'b1;
                row <= row + 1'b1;
            end

            if (state == DONE) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nfc_page_copy_engine.sv
// Bench for the page-copy engine: behavioural flash A/B models, a reference
// transaction list per run, table-driven and random runs plus hand sequences
// for reset, start-during-DONE and mid-transfer reset.
module tb_nfc_page_copy_engine;
    localparam int PAGE_BYTES  = 528;
    localparam int ADDR_CYCLES = 3;
    localparam int ROW_W       = 16;
    localparam int T_WB        = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Clock generation.
    always #5 clk = ~clk;

    nfc_page_copy_engine_if #(.ROW_W(ROW_W)) bus ();

    nfc_page_copy_engine #(
        .PAGE_BYTES(PAGE_BYTES), .ADDR_CYCLES(ADDR_CYCLES), .ROW_W(ROW_W), .T_WB(T_WB)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Run configuration, written by the stimulus only.
    logic [7:0]  key      = 8'h00;
    logic [15:0] fail_vec = 16'h0000;
    int          rb_a_dly = 0;
    int          rb_b_dly = 0;
    int          st_base  = 0;

    // Flash-model and monitor state, written by the monitor only.
    int          cyc = 0;
    logic [9:0]  obs_a[$];
    logic [9:0]  obs_b[$];
    int          xfer_q[$];
    int          a_idx = 0, a_addr_n = 0, rb_a_cnt = 0, rb_b_cnt = 0;
    int          st_n = 0, t0 = 0, b_data_n = 0, ctrl_viol = 0, rb_viol = 0;
    logic [15:0] a_row = 16'h0000;
    logic        prev_ren_a = 1'b1, prev_ren_b = 1'b1, ren_seen = 1'b0;

    function automatic logic [7:0] a_byte(input logic [15:0] r, input int k, input logic [7:0] kk);
        logic [15:0] p;
        p = 16'(kk) * 16'(r[7:0]);
        return 8'(k) + p[7:0];
    endfunction

    assign bus.F_IO_A_in = a_byte(a_row, a_idx, key);
    assign bus.F_RB_A    = (rb_a_cnt == 0);
    assign bus.F_RB_B    = (rb_b_cnt == 0);
    assign bus.F_IO_B_in = fail_vec[4'(st_n - st_base)] ? 8'h01 : 8'hC0;

    // Flash monitor: logs cmd/addr/data writes, serves A data and status, models RB.
    always @(negedge clk) begin
        cyc++;
        if (rb_a_cnt > 0 && !bus.F_REN_A) rb_viol++;
        if (rb_b_cnt > 0 && !bus.F_REN_B) rb_viol++;
        if (rb_a_cnt > 0) rb_a_cnt--;
        if (rb_b_cnt > 0) rb_b_cnt--;
        if ((!bus.F_REN_A && !bus.F_WEN_A) || (bus.F_CLE_A && bus.F_ALE_A) || (!bus.F_REN_A && bus.F_IO_A_oe))
            ctrl_viol++;
        if ((!bus.F_REN_B && !bus.F_WEN_B) || (bus.F_CLE_B && bus.F_ALE_B) || (!bus.F_REN_B && bus.F_IO_B_oe))
            ctrl_viol++;
        if (!bus.F_WEN_A) begin
            if (bus.F_CLE_A) begin
                obs_a.push_back({2'd0, bus.F_IO_A_out});
                a_idx = 0; a_addr_n = 0; ren_seen = 1'b0;
            end else if (bus.F_ALE_A) begin
                obs_a.push_back({2'd1, bus.F_IO_A_out});
                a_addr_n++;
                if (a_addr_n == 2) a_row[7:0]  = bus.F_IO_A_out;
                if (a_addr_n == 3) begin
                    a_row[15:8] = bus.F_IO_A_out;
                    rb_a_cnt = rb_a_dly;
                end
            end else begin
                obs_a.push_back({2'd2, bus.F_IO_A_out});
            end
        end
        if (!bus.F_REN_A && !ren_seen) begin
            ren_seen = 1'b1;
            t0 = cyc;
        end
        if (bus.F_REN_A && !prev_ren_a) a_idx++;
        prev_ren_a = bus.F_REN_A;
        if (!bus.F_WEN_B) begin
            if (bus.F_CLE_B) begin
                obs_b.push_back({2'd0, bus.F_IO_B_out});
                if (bus.F_IO_B_out == 8'h10) begin
                    xfer_q.push_back(cyc - t0);
                    rb_b_cnt = rb_b_dly;
                end
            end else if (bus.F_ALE_B) begin
                obs_b.push_back({2'd1, bus.F_IO_B_out});
            end else begin
                obs_b.push_back({2'd2, bus.F_IO_B_out});
                b_data_n++;
            end
        end
        if (bus.F_REN_B && !prev_ren_b) st_n++;
        prev_ren_b = bus.F_REN_B;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cmp_seq(input string nm, input bit is_b, input int base, input logic [9:0] exp_q[$]);
        int n;
        int diff;
        n    = is_b ? obs_b.size() - base : obs_a.size() - base;
        diff = -1;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            if (diff < 0 && (is_b ? obs_b[base+i] : obs_a[base+i]) !== exp_q[i]) diff = i;
        end
        chk({nm, ".len"}, n, exp_q.size());
        chk({nm, ".first_diff"}, diff, -1);
    endtask

    function automatic void ref_status(input logic [15:0] ps, input logic [15:0] pc, input logic [15:0] fv,
                                       output bit e, output logic [15:0] ep);
        e = 1'b0;
        ep = 16'h0000;
        for (int i = 0; i < int'(pc); i++) begin
            if (fv[i] && !e) begin
                e = 1'b1;
                ep = ps + 16'(i);
            end
        end
    endfunction

    task automatic run_copy(input string nm, input logic [15:0] ps, input logic [15:0] pc,
                            input logic [7:0] k, input logic [15:0] fv, input int rda, input int rdb,
                            input bit poke, input bit exp_err, input logic [15:0] exp_ep);
        logic [9:0]  exp_a[$];
        logic [9:0]  exp_b[$];
        logic [15:0] r;
        int a_base, b_base, x_base, cv0, rv0, busy_n, gap, budget, xbad;
        bit to;

        key = k; fail_vec = fv; rb_a_dly = rda; rb_b_dly = rdb;
        for (int i = 0; i < int'(pc); i++) begin
            r = ps + 16'(i);
            exp_a.push_back({2'd0, 8'h00});
            exp_a.push_back({2'd1, 8'h00});
            exp_a.push_back({2'd1, r[7:0]});
            exp_a.push_back({2'd1, r[15:8]});
            exp_b.push_back({2'd0, 8'h80});
            exp_b.push_back({2'd1, 8'h00});
            exp_b.push_back({2'd1, r[7:0]});
            exp_b.push_back({2'd1, r[15:8]});
            for (int b = 0; b < PAGE_BYTES; b++) exp_b.push_back({2'd2, a_byte(r, b, k)});
            exp_b.push_back({2'd0, 8'h10});
            exp_b.push_back({2'd0, 8'h70});
        end
        a_base = obs_a.size(); b_base = obs_b.size(); x_base = xfer_q.size();
        st_base = st_n; cv0 = ctrl_viol; rv0 = rb_viol;
        budget = int'(pc) * (2*PAGE_BYTES + 100 + rda + rdb) + 100;

        @(negedge clk);
        bus.start = 1'b1; bus.page_start = ps; bus.page_cnt = pc;
        @(negedge clk);
        bus.start = 1'b0; bus.page_start = 16'($urandom); bus.page_cnt = 16'($urandom);
        busy_n = 0; gap = 0; to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (bus.done) begin
                to = 1'b0;
                break;
            end
            if (bus.busy) busy_n++;
            if (bus.busy == bus.done) gap++;
            bus.start = poke && (c == 40);
            if (poke && c == 40) begin
                bus.page_start = 16'($urandom);
                bus.page_cnt   = 16'($urandom_range(1, 5));
            end
            @(negedge clk);
        end
        bus.start = 1'b0;

        chk({nm, ".timeout"}, 32'(to), 0);
        chk({nm, ".done"}, 32'(bus.done), 1);
        chk({nm, ".busy_end"}, 32'(bus.busy), 0);
        chk({nm, ".busy_gap"}, gap, 0);
        chk({nm, ".err"}, 32'(bus.err), 32'(exp_err));
        chk({nm, ".err_page"}, 32'(bus.err_page), 32'(exp_ep));
        cmp_seq({nm, ".flash_a"}, 1'b0, a_base, exp_a);
        cmp_seq({nm, ".flash_b"}, 1'b1, b_base, exp_b);
        chk({nm, ".status_reads"}, st_n - st_base, 32'(pc));
        chk({nm, ".xfer_count"}, xfer_q.size() - x_base, 32'(pc));
        xbad = 0;
        for (int i = x_base; i < xfer_q.size(); i++) if (xfer_q[i] != 2*PAGE_BYTES + 1) xbad++;
        chk({nm, ".xfer_len"}, xbad, 0);
        chk({nm, ".ctrl_excl"}, ctrl_viol - cv0, 0);
        chk({nm, ".ren_before_rb"}, rb_viol - rv0, 0);
        if (pc == 16'h0000) chk({nm, ".busy_cycles"}, busy_n, 1);
    endtask

    typedef struct {
        string       nm;
        logic [15:0] ps;
        logic [15:0] pc;
        logic [7:0]  key;
        logic [15:0] fv;
        int          rda;
        int          rdb;
        bit          poke;
        bit          exp_err;
        logic [15:0] exp_ep;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          e;
        logic [15:0] ep, ps, pc, fv;
        logic [7:0]  k;
        int          b0;
        bit          to;

        vecs[0] = '{"single",    16'h0005, 16'd1, 8'h00, 16'h0000,   3,  5, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{"wrap",      16'hFFFE, 16'd3, 8'h01, 16'h0000,   2,  2, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{"stat_fail", 16'h0010, 16'd4, 8'h03, 16'h0002,   1,  4, 1'b0, 1'b1, 16'h0011};
        vecs[3] = '{"zero_cnt",  16'h1234, 16'd0, 8'h00, 16'h0000,   0,  0, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{"rb_stretch",16'h0040, 16'd1, 8'h05, 16'h0000, 200,  3, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{"first_err", 16'h00FF, 16'd2, 8'h07, 16'h0003,   0,  1, 1'b0, 1'b1, 16'h00FF};

        bus.start = 1'b0; bus.page_start = 16'h0000; bus.page_cnt = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset.flash_a", {bus.F_CLE_A, bus.F_ALE_A, bus.F_REN_A, bus.F_WEN_A, bus.F_IO_A_oe, bus.F_IO_A_out},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        chk("reset.flash_b", {bus.F_CLE_B, bus.F_ALE_B, bus.F_REN_B, bus.F_WEN_B, bus.F_IO_B_oe, bus.F_IO_B_out},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
        chk("reset.status", {bus.busy, bus.done, bus.err, bus.err_page}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle.status", {bus.busy, bus.done, bus.err}, 0);

        for (int i = 0; i < 6; i++)
            run_copy(vecs[i].nm, vecs[i].ps, vecs[i].pc, vecs[i].key, vecs[i].fv,
                     vecs[i].rda, vecs[i].rdb, vecs[i].poke, vecs[i].exp_err, vecs[i].exp_ep);

        for (int i = 0; i < 4; i++) begin
            ps = 16'($urandom);
            pc = 16'($urandom_range(1, 3));
            k  = 8'($urandom);
            fv = 16'($urandom);
            ref_status(ps, pc, fv, e, ep);
            run_copy($sformatf("rand%0d", i), ps, pc, k, fv, $urandom_range(0, 30),
                     $urandom_range(0, 30), 1'b1, e, ep);
        end

        // start during DONE is ignored, the next cycle in IDLE accepts it
        @(negedge clk);
        bus.start = 1'b1; bus.page_cnt = 16'h0000; bus.page_start = 16'h0077;
        @(negedge clk);
        chk("done_start.in_done", {bus.busy, bus.done}, 2'b10);
        @(negedge clk);
        chk("done_start.ignored", {bus.busy, bus.done}, 2'b01);
        @(negedge clk);
        chk("done_start.accepted", {bus.busy, bus.done}, 2'b10);
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_start.finished", {bus.busy, bus.done}, 2'b01);

        // reset in the middle of a page transfer
        key = 8'h09; fail_vec = 16'h0000; rb_a_dly = 2; rb_b_dly = 2;
        b0 = b_data_n;
        @(negedge clk);
        bus.start = 1'b1; bus.page_start = 16'h0020; bus.page_cnt = 16'd2;
        @(negedge clk);
        bus.start = 1'b0;
        to = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (b_data_n - b0 >= 100) begin
                to = 1'b0;
                break;
            end
        end
        chk("mid_reset.reach_byte100", 32'(to), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset.pins", {bus.F_REN_A, bus.F_WEN_A, bus.F_REN_B, bus.F_WEN_B, bus.F_IO_A_oe, bus.F_IO_B_oe,
                               bus.F_CLE_A, bus.F_ALE_A, bus.F_CLE_B, bus.F_ALE_B}, 10'b1111_00_0000);
        chk("mid_reset.busy", {bus.busy, bus.done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_copy("after_reset", 16'h0020, 16'd1, 8'h09, 16'h0000, 2, 2, 1'b0, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
